// File: rtl/spiflash_reader.sv
// spiflash_reader: SPI mode-0 flash read engine with a one-byte output buffer.
// Sequence: 0x03 command, 24-bit address, then len bytes clocked in MSB first.
// Define SPIFLASH_FASTREAD_EN to issue 0x0B and insert 8 dummy clocks before data.
module spiflash_reader #(
    parameter int CLK_DIV = 2,  // SCK half-period in wb_clk_i cycles (1..255)
    parameter int CS_IDLE = 4   // minimum flash_csb high time between transactions
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

`ifdef SPIFLASH_FASTREAD_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif
    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [15:0] DESEL_LAST = (CS_IDLE > 1) ? 16'(CS_IDLE - 1) : 16'd0;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL} state_t;

    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic        sck;
    logic [5:0]  bit_cnt;     // rising edges within the current phase / byte
    logic [31:0] shreg;       // outgoing command + address, MSB on flash_io0
    logic [15:0] bytes_left;  // bytes still to be clocked in
    logic [7:0]  rx;          // assembly register, doubles as the parked byte
    logic        pend;        // rx holds a complete byte that could not be handed over
    logic [15:0] desel_cnt;

    logic shifting, gate, tick, rise, fall, accept, free, byte_done;

    // SCK edge strobes and handshake qualifiers
    always_comb begin
        shifting  = (state == S_CMD) || (state == S_ADDR) || (state == S_DUMMY) || (state == S_DATA);
        // at a byte boundary SCK is held low while a byte is parked or no bytes remain
        gate      = (state == S_DATA) && (pend || (bytes_left == 16'd0));
        tick      = (div_cnt == DIV_LAST);
        rise      = shifting && tick && !sck && !gate;
        fall      = shifting && tick && sck;
        accept    = req_valid && req_ready;
        free      = !data_valid || data_ready;
        byte_done = rise && (state == S_DATA) && (bit_cnt == 6'd7);
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state: phases advance on the falling edge that follows their last bit
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (req_len == 16'd0) ? S_DESEL : S_CMD;
            S_CMD:   if (fall && bit_cnt == 6'd8) state_nxt = S_ADDR;
`ifdef SPIFLASH_FASTREAD_EN
            S_ADDR:  if (fall && bit_cnt == 6'd32) state_nxt = S_DUMMY;
`else
            S_ADDR:  if (fall && bit_cnt == 6'd32) state_nxt = S_DATA;
`endif
            S_DUMMY: if (fall && bit_cnt == 6'd8) state_nxt = S_DATA;
            S_DATA:  if (!sck && bytes_left == 16'd0 && !pend) state_nxt = S_DESEL;
            S_DESEL: if (desel_cnt == 16'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: chip select, pins and request-side status
    always_comb begin
        busy      = (state != S_IDLE);
        flash_csb = !shifting;
        flash_clk = sck && shifting;
        flash_io0 = ((state == S_CMD) || (state == S_ADDR)) ? shreg[31] : 1'b0;
        req_ready = (state == S_IDLE) && !data_valid && !wb_rst_i;
    end

    // SCK divider, bit/byte counters, MOSI shifter and MISO assembly
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_cnt    <= '0;
            sck        <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            bytes_left <= '0;
            rx         <= '0;
            desel_cnt  <= '0;
        end else begin
            // stalled low or idle: restart so the next rise comes a full half-period later
            if (!shifting || (gate && !sck) || tick) div_cnt <= '0;
            else                                     div_cnt <= div_cnt + 8'd1;

            if (state == S_IDLE && accept) begin
                shreg      <= {CMD_BYTE, req_addr};
                bytes_left <= req_len;
                bit_cnt    <= '0;
                desel_cnt  <= '0;
            end

            if (rise) begin
                sck <= 1'b1;
                if (state == S_DATA) begin
                    rx <= {rx[6:0], flash_io1};
                    if (bit_cnt == 6'd7) begin
                        bit_cnt    <= '0;
                        bytes_left <= bytes_left - 16'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end

            if (fall) begin
                sck   <= 1'b0;
                shreg <= {shreg[30:0], 1'b0};
                if ((state == S_ADDR && bit_cnt == 6'd32) || (state == S_DUMMY && bit_cnt == 6'd8))
                    bit_cnt <= '0;
            end

            if (state == S_DATA && state_nxt == S_DESEL) desel_cnt <= DESEL_LAST;
            else if (state == S_DESEL && desel_cnt != 16'd0) desel_cnt <= desel_cnt - 16'd1;
        end
    end

    // Output byte buffer: load straight from the shifter when free, else park in rx
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            pend       <= 1'b0;
        end else if (byte_done) begin
            if (free) begin
                data_out   <= {rx[6:0], flash_io1};
                data_valid <= 1'b1;
            end else begin
                pend <= 1'b1;
            end
        end else if (pend && free) begin
            data_out   <= rx;
            data_valid <= 1'b1;
            pend       <= 1'b0;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule
